bcd_updown_timer: RTL and testbench
===================================

Name: bcd_updown_timer

Overview:
- Parametrised BCD hh:mm:ss timer. Counts up as a stopwatch or down from a loaded preset.
- Supports run/pause, clear and preset load, with a terminal "done" event.
- Sits between the button/edge-detect front end and the 6-digit seven-segment display driver. It replaces the fixed-rate, up-only timer of the previous stage.

Parameters:
- TICK_CYCLES, 50000000, clock cycles per 1 s tick. Legal range >= 2.
- HH_MAX, 99, maximum hours value in decimal. Legal range 1..99.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- run_tgl  in  1  one-cycle active-high strobe: start/pause toggle
- clr  in  1  one-cycle active-high strobe: clear to 00:00:00, go IDLE
- load  in  1  one-cycle active-high strobe: load preset
- preset  in  24  BCD hh:mm:ss preset; [23:20]=H tens ... [3:0]=S units
- dir  in  1  0 = count up, 1 = count down
- out  out  24  current BCD value, same digit layout as preset
- running  out  1  high while in state RUN
- tick  out  1  one-cycle pulse on each 1 s count update
- done  out  1  one-cycle pulse when the terminal value is reached

Behaviour:
- Reset (rst=0, async):
  - out=0, prescaler=0, state=IDLE, latched direction=up.
  - running=0, tick=0, done=0.
  - Reset mid-operation aborts immediately.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN). All outputs are registered.
- Strobe priority: clr > load > run_tgl. Lower-priority strobes in the same cycle are ignored.
- clr, from any state: out=0, prescaler=0, next state IDLE, no done pulse.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Sets out=preset and prescaler=0; next state IDLE.
  - preset is ignored (out unchanged) if any digit is illegal: S/M units > 9, S/M tens > 5, H digits > 9, or hours > HH_MAX.
- run_tgl in IDLE or DONE:
  - Latches dir, then enters RUN.
  - Exception: stays put (no state change) if the latched dir=1 and out==0, or dir=0 and out==HH_MAX:59:59.
- run_tgl in RUN: enters PAUSE. Prescaler is held, not cleared.
- run_tgl in PAUSE: returns to RUN. Prescaler resumes from its held value.
- dir changes are ignored in RUN and PAUSE.
- Prescaler:
  - Counts only in RUN, from 0 to TICK_CYCLES-1.
  - On the cycle it equals TICK_CYCLES-1 it wraps to 0 and a count update occurs.
  - tick is asserted in the cycle after that edge, aligned with the new out value.
  - First tick occurs TICK_CYCLES cycles after entering RUN from a zeroed prescaler.
- Up count: BCD increment.
  - S units 9->0 carries to S tens; S tens 5->0 carries to M units.
  - Minutes handled the same way; minute carry increments hours (BCD).
- Down count: BCD decrement.
  - S units 0->9 borrows from S tens; S tens 0->5 borrows from M units.
  - Minutes handled the same way; minute borrow decrements hours.
- Terminal:
  - Up: the update that produces HH_MAX:59:59 enters DONE.
  - Down: the update that produces 00:00:00 enters DONE.
  - done pulses in the same cycle as tick for that update. out holds; no wrap-around.
- In IDLE, PAUSE and DONE, out is frozen and tick=0.

Optional Feature:
- Macro: BCD_TIMER_LAP_CAPTURE_EN.
- When defined, adds these ports:
  - lap (in 1, strobe)
  - lap_out (out 24)
  - lap_valid (out 1)
- Behaviour when defined:
  - lap in RUN: lap_out <= out, lap_valid <= 1 on the next cycle. If a count update occurs in the same cycle, the pre-update value is captured.
  - lap in other states is ignored.
  - clr and reset clear lap_out to 0 and lap_valid to 0.
- When undefined: the ports do not exist and no capture register is built.

Test Plan (TICK_CYCLES=4 unless stated):
- Async reset: assert rst=0 mid-RUN -> out=0x000000, running=0, tick=0, done=0 immediately. After release, IDLE.
- Up count: dir=0, run_tgl -> tick every 4 cycles. After 60 ticks out=0x000100; after 3600 ticks out=0x010000.
- Pause/resume: pause 2 cycles after the 10th tick, hold 100 cycles -> out stays 0x000010. Resume with run_tgl -> 11th tick exactly 2 cycles later (prescaler phase preserved).
- Countdown: load preset 0x000102, dir=1, run_tgl -> after 61 ticks out=0x000001. After 62 ticks out=0x000000, done=1 for one cycle with tick, state DONE, running=0. Further run_tgl is ignored.
- Max/terminal with HH_MAX=1: load 0x015958, dir=0, run -> one tick gives 0x015959 with done pulse. No further change. Loading 0x020000 is ignored (exceeds HH_MAX).
- Priority/illegal: clr+run_tgl same cycle in RUN -> out=0, IDLE, running=0. load with preset 0x00007A -> out unchanged. load during RUN -> ignored.

Source files
------------

// File: rtl/bcd_updown_timer.sv
// bcd_updown_timer -- BCD hh:mm:ss stopwatch / countdown timer.
//
// Counts up from the current value or down towards 00:00:00, one BCD step
// per TICK_CYCLES clock cycles while in RUN. Supports run/pause toggling,
// clear, validated preset load and a one-cycle "done" pulse on reaching
// the terminal value (HH_MAX:59:59 counting up, 00:00:00 counting down).
//
// Optional build macro: BCD_TIMER_LAP_CAPTURE_EN
//   When defined, adds lap / lap_out / lap_valid. A lap strobe in RUN
//   captures the displayed value. When undefined, neither the ports nor
//   the capture register exist.
//
// Digit layout of preset/out: [23:20] H tens, [19:16] H units,
// [15:12] M tens, [11:8] M units, [7:4] S tens, [3:0] S units.

module bcd_updown_timer #(
  parameter int TICK_CYCLES = 50000000,
  parameter int HH_MAX      = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_tgl,
  input  logic        clr,
  input  logic        load,
  input  logic [23:0] preset,
  input  logic        dir,
  output logic [23:0] out,
  output logic        running,
  output logic        tick,
  output logic        done
`ifdef BCD_TIMER_LAP_CAPTURE_EN
  ,
  input  logic        lap,
  output logic [23:0] lap_out,
  output logic        lap_valid
`endif
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  // Largest displayable value: HH_MAX:59:59 in BCD.
  localparam logic [3:0]  HMAX_T  = 4'(HH_MAX / 10);
  localparam logic [3:0]  HMAX_U  = 4'(HH_MAX % 10);
  localparam logic [23:0] MAX_VAL = {HMAX_T, HMAX_U, 8'h59, 8'h59};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   out_q, out_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          running_q, running_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;

  // ------------------------------------------------------------------
  // BCD increment / decrement of the current value, one digit per
  // generate slice with a ripple carry/borrow. Tens-of-seconds and
  // tens-of-minutes roll at 5, every other digit at 9. Hours never need
  // to wrap past 99 or below 00 because the terminal value stops the
  // count before that can happen.
  // ------------------------------------------------------------------
  logic [23:0] inc_val;
  logic [23:0] dec_val;
  logic [5:0]  inc_c;
  logic [5:0]  dec_b;

  assign inc_c[0] = 1'b1;
  assign dec_b[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_dig
      localparam logic [3:0] LIM = (gi == 1 || gi == 3) ? 4'd5 : 4'd9;
      logic [3:0] d;
      assign d = out_q[4*gi +: 4];

      assign inc_val[4*gi +: 4] = !inc_c[gi] ? d :
                                  (d == LIM) ? 4'd0 : d + 4'd1;
      assign dec_val[4*gi +: 4] = !dec_b[gi] ? d :
                                  (d == 4'd0) ? LIM : d - 4'd1;

      if (gi < 5) begin : g_chain
        assign inc_c[gi+1] = inc_c[gi] && (d == LIM);
        assign dec_b[gi+1] = dec_b[gi] && (d == 4'd0);
      end
    end
  endgenerate

  // Value after one count step in the latched direction, and the value
  // at which that direction terminates.
  logic [23:0] step_val;
  logic [23:0] term_val;
  assign step_val = dir_q ? dec_val : inc_val;
  assign term_val = dir_q ? 24'h000000 : MAX_VAL;

  // ------------------------------------------------------------------
  // Preset validation: every digit in range and hours within HH_MAX.
  // ------------------------------------------------------------------
  logic [6:0] preset_hours;
  logic       preset_ok;

  // Check each digit of the preset and the combined hour value.
  always_comb begin
    preset_hours = 7'(preset[23:20]) * 7'd10 + 7'(preset[19:16]);
    preset_ok    = (preset[3:0]   <= 4'd9) &&
                   (preset[7:4]   <= 4'd5) &&
                   (preset[11:8]  <= 4'd9) &&
                   (preset[15:12] <= 4'd5) &&
                   (preset[19:16] <= 4'd9) &&
                   (preset[23:20] <= 4'd9) &&
                   (preset_hours  <= 7'(HH_MAX));
  end

  // Starting would immediately be past the terminal value in the
  // requested direction, so a run request is refused.
  logic start_blocked;
  assign start_blocked = dir ? (out_q == 24'h000000) : (out_q == MAX_VAL);

  // ------------------------------------------------------------------
  // Next-state and next-output logic. Strobe priority is
  // clr > load > run_tgl; an asserted higher-priority strobe masks the
  // lower ones even when it is itself not accepted in the current state.
  // The prescaler step runs first so that a pause or terminal event in
  // the same cycle still sees the count update.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (clr) begin
      out_d   = 24'h000000;
      presc_d = '0;
      state_d = IDLE;
    end else begin
      if (state_q == RUN) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          out_d   = step_val;
          tick_d  = 1'b1;
          if (step_val == term_val) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      if (load) begin
        if (state_q != RUN && preset_ok) begin
          out_d   = preset;
          presc_d = '0;
          state_d = IDLE;
        end
      end else if (run_tgl) begin
        unique case (state_q)
          IDLE, DONE: begin
            if (!start_blocked) begin
              dir_d   = dir;
              state_d = RUN;
            end
          end
          RUN: begin
            // A terminal update in this same cycle takes precedence.
            if (state_d == RUN) begin
              state_d = PAUSE;
            end
          end
          PAUSE: begin
            state_d = RUN;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end

    running_d = (state_d == RUN);
  end

  // State and output registers; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      out_q     <= 24'h000000;
      presc_q   <= '0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign out     = out_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign done    = done_q;

`ifdef BCD_TIMER_LAP_CAPTURE_EN
  logic [23:0] lap_out_q, lap_out_d;
  logic        lap_valid_q, lap_valid_d;

  // Lap capture takes the value shown before any same-cycle update.
  always_comb begin
    lap_out_d   = lap_out_q;
    lap_valid_d = lap_valid_q;
    if (clr) begin
      lap_out_d   = 24'h000000;
      lap_valid_d = 1'b0;
    end else if (lap && state_q == RUN) begin
      lap_out_d   = out_q;
      lap_valid_d = 1'b1;
    end
  end

  // Lap capture register, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_out_q   <= 24'h000000;
      lap_valid_q <= 1'b0;
    end else begin
      lap_out_q   <= lap_out_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_out   = lap_out_q;
  assign lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Self-checking bench for bcd_updown_timer.
// Two instances share stimulus: u0 with HH_MAX=99, u1 with HH_MAX=1,
// both with TICK_CYCLES=4. Expected tick results are queued as each
// wait is started and popped when the DUT raises tick.

module tb_bcd_updown_timer;

  localparam int TC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        run_tgl;
  logic        clr;
  logic        load;
  logic        dir;
  logic [23:0] preset;

  logic [23:0] out0, out1;
  logic        running0, running1;
  logic        tick0, tick1;
  logic        done0, done1;

  bcd_updown_timer #(.TICK_CYCLES(TC), .HH_MAX(99)) u0 (
    .clk     (clk),
    .rst     (rst),
    .run_tgl (run_tgl),
    .clr     (clr),
    .load    (load),
    .preset  (preset),
    .dir     (dir),
    .out     (out0),
    .running (running0),
    .tick    (tick0),
    .done    (done0)
  );

  bcd_updown_timer #(.TICK_CYCLES(TC), .HH_MAX(1)) u1 (
    .clk     (clk),
    .rst     (rst),
    .run_tgl (run_tgl),
    .clr     (clr),
    .load    (load),
    .preset  (preset),
    .dir     (dir),
    .out     (out1),
    .running (running1),
    .tick    (tick1),
    .done    (done1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [23:0] val;
    logic        dn;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference conversion from elapsed seconds to the BCD display layout.
  function automatic logic [23:0] to_bcd(input int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // One-cycle strobe, driven at a negedge and released at the next.
  task automatic strobe(input logic r, input logic c, input logic l);
    run_tgl = r;
    clr     = c;
    load    = l;
    @(negedge clk);
    run_tgl = 1'b0;
    clr     = 1'b0;
    load    = 1'b0;
  endtask

  // Queue the expected result, then wait (bounded) for the tick.
  task automatic expect_tick(input bit sel, input logic [23:0] e_val,
                             input logic e_done, input int e_gap);
    exp_t e;
    int   gap;
    bit   seen;
    e.val = e_val;
    e.dn  = e_done;
    sb_q.push_back(e);
    gap  = 0;
    seen = 1'b0;
    while (!seen && gap < 64) begin
      @(negedge clk);
      gap++;
      seen = sel ? tick1 : tick0;
    end
    chk("tick_seen", 32'(seen), 32'd1);
    e = sb_q.pop_front();
    if (seen) begin
      chk("tick_out",  32'(sel ? out1 : out0), 32'(e.val));
      chk("tick_done", 32'(sel ? done1 : done0), 32'(e.dn));
      if (e_gap > 0) chk("tick_gap", 32'(gap), 32'(e_gap));
    end
  endtask

  // Watch a DUT for n cycles and report whether any tick appeared.
  task automatic watch_quiet(input bit sel, input int n, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (sel ? tick1 : tick0) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int secs;

    rst = 1'b0; run_tgl = 1'b0; clr = 1'b0; load = 1'b0;
    dir = 1'b0; preset = 24'h000000;
    repeat (2) @(negedge clk);
    $display("txn: reset state");
    chk("rst_out",     32'(out0), 32'h0);
    chk("rst_running", 32'(running0), 32'd0);
    chk("rst_tick",    32'(tick0), 32'd0);
    chk("rst_done",    32'(done0), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Up count with a pause after the 10th tick.
    $display("txn: up count 3600 ticks with pause/resume");
    dir = 1'b0;
    strobe(1'b1, 1'b0, 1'b0);
    chk("run_running", 32'(running0), 32'd1);
    secs = 0;
    for (int i = 1; i <= 3600; i++) begin
      secs++;
      expect_tick(1'b0, to_bcd(secs), 1'b0, (i == 11) ? 1 : TC);
      if (i == 10) begin
        repeat (2) @(negedge clk);
        strobe(1'b1, 1'b0, 1'b0);
        chk("pause_running", 32'(running0), 32'd0);
        watch_quiet(1'b0, 100, "pause_no_tick");
        chk("pause_hold", 32'(out0), 32'h000010);
        strobe(1'b1, 1'b0, 1'b0);
        chk("resume_running", 32'(running0), 32'd1);
      end
      if (i == 60)   chk("up_60",   32'(out0), 32'h000100);
      if (i == 3600) chk("up_3600", 32'(out0), 32'h010000);
    end

    // Asynchronous reset between clock edges while running.
    $display("txn: async reset mid-run");
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out",     32'(out0), 32'h0);
    chk("arst_running", 32'(running0), 32'd0);
    chk("arst_tick",    32'(tick0), 32'd0);
    chk("arst_done",    32'(done0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    watch_quiet(1'b0, 12, "arst_idle_no_tick");
    chk("arst_idle_out",     32'(out0), 32'h0);
    chk("arst_idle_running", 32'(running0), 32'd0);

    // Countdown from 00:01:02 to done.
    $display("txn: countdown from 000102");
    preset = 24'h000102;
    strobe(1'b0, 1'b0, 1'b1);
    chk("cd_load", 32'(out0), 32'h000102);
    dir = 1'b1;
    strobe(1'b1, 1'b0, 1'b0);
    secs = 62;
    for (int i = 1; i <= 62; i++) begin
      secs--;
      expect_tick(1'b0, to_bcd(secs), (i == 62), TC);
      if (i == 61) chk("cd_61", 32'(out0), 32'h000001);
    end
    chk("cd_done_running", 32'(running0), 32'd0);
    @(negedge clk);
    chk("cd_done_pulse", 32'(done0), 32'd0);
    chk("cd_tick_pulse", 32'(tick0), 32'd0);
    strobe(1'b1, 1'b0, 1'b0);
    watch_quiet(1'b0, 10, "cd_rerun_no_tick");
    chk("cd_rerun_running", 32'(running0), 32'd0);
    chk("cd_rerun_out",     32'(out0), 32'h0);

    // Terminal at HH_MAX=1 on u1.
    $display("txn: hh_max=1 terminal");
    preset = 24'h015958;
    strobe(1'b0, 1'b0, 1'b1);
    chk("max_load", 32'(out1), 32'h015958);
    dir = 1'b0;
    strobe(1'b1, 1'b0, 1'b0);
    expect_tick(1'b1, 24'h015959, 1'b1, TC);
    chk("max_running", 32'(running1), 32'd0);
    watch_quiet(1'b1, 12, "max_no_tick");
    chk("max_hold", 32'(out1), 32'h015959);
    strobe(1'b1, 1'b0, 1'b0);
    chk("max_rerun_running", 32'(running1), 32'd0);
    preset = 24'h020000;
    strobe(1'b0, 1'b0, 1'b1);
    chk("max_bad_load", 32'(out1), 32'h015959);

    // Priority and illegal presets on u0.
    $display("txn: priority and illegal preset");
    strobe(1'b0, 1'b1, 1'b0);
    chk("clr_out", 32'(out0), 32'h0);
    dir = 1'b0;
    strobe(1'b1, 1'b0, 1'b0);
    expect_tick(1'b0, 24'h000001, 1'b0, TC);
    preset = 24'h123456;
    strobe(1'b0, 1'b0, 1'b1);
    chk("load_in_run_out",     32'(out0), 32'h000001);
    chk("load_in_run_running", 32'(running0), 32'd1);
    strobe(1'b1, 1'b1, 1'b0);
    chk("clr_run_out",     32'(out0), 32'h0);
    chk("clr_run_running", 32'(running0), 32'd0);
    watch_quiet(1'b0, 10, "clr_run_no_tick");
    preset = 24'h000305;
    strobe(1'b0, 1'b0, 1'b1);
    chk("legal_load", 32'(out0), 32'h000305);
    preset = 24'h00007A;
    strobe(1'b0, 1'b0, 1'b1);
    chk("illegal_su", 32'(out0), 32'h000305);
    preset = 24'h006000;
    strobe(1'b0, 1'b0, 1'b1);
    chk("illegal_mt", 32'(out0), 32'h000305);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
